// File: rtl/mul_issue_sched.sv
// Issue scheduler and completion buffer for the 8-stage pipelined multiplier.
// Round-robin issue gated by credits, so every in-flight result always has a buffer slot.
module mul_issue_sched #(
  parameter int NREQ      = 2,
  parameter int STAGE     = 8,
  parameter int BUF_DEPTH = 4,
  parameter int XLEN      = 32,
  parameter int PRF_LEN   = 6,
  parameter int ROB_LEN   = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req_valid,
  input  logic                         squash,
  output logic [NREQ-1:0]              gnt,
  output logic [$clog2(NREQ)-1:0]      gnt_idx,
  output logic                         mul_enable,
  input  logic                         mul_valid,
  input  logic [XLEN-1:0]              mul_value,
  input  logic [PRF_LEN-1:0]           mul_prf_idx,
  input  logic [ROB_LEN-1:0]           mul_rob_idx,
  input  logic [XLEN-1:0]              mul_PC,
  output logic                         cdb_req,
  input  logic                         cdb_grant,
  output logic [XLEN-1:0]              cdb_value,
  output logic [PRF_LEN-1:0]           cdb_prf_idx,
  output logic [ROB_LEN-1:0]           cdb_rob_idx,
  output logic [XLEN-1:0]              cdb_PC,
  output logic [$clog2(BUF_DEPTH):0]   credits
);

  localparam int IDX_W   = $clog2(NREQ);
  localparam int PTR_W   = $clog2(BUF_DEPTH);
  localparam int CRED_W  = PTR_W + 1;
  localparam int ENTRY_W = 2 * XLEN + PRF_LEN + ROB_LEN;
  localparam logic [CRED_W-1:0] DEPTH_C = CRED_W'(BUF_DEPTH);

  logic [IDX_W-1:0]   rr_ptr;
  logic [STAGE-1:0]   stage_valid;
  logic [ENTRY_W-1:0] buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CRED_W-1:0]  count;
  logic [CRED_W-1:0]  inflight;
  logic               issue_ok;
  logic               found;
  logic [IDX_W-1:0]   cand;
  logic               live;
  logic               buf_empty;
  logic               fire;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] incoming;
  logic [ENTRY_W-1:0] presented;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int s = 0; s < STAGE; s++) begin
      inflight = inflight + CRED_W'(stage_valid[s]);
    end
  end

  // In-flight plus buffered results never exceed BUF_DEPTH, so this cannot underflow.
  assign credits  = DEPTH_C - count - inflight;
  assign issue_ok = reset & ~squash & (credits != '0);

  always_comb begin
    found   = 1'b0;
    cand    = '0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = rr_ptr + IDX_W'(k);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (!issue_ok) begin
      found   = 1'b0;
      gnt_idx = '0;
    end
    gnt = found ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  end

  assign mul_enable = |gnt;

  // Pipeline outputs without a tracking bit belong to squashed issues and are dropped.
  assign live      = mul_valid & stage_valid[STAGE-1];
  assign buf_empty = (count == '0);
  assign incoming  = {mul_value, mul_prf_idx, mul_rob_idx, mul_PC};

  // CDB handshake: cdb_req is the valid and cdb_grant the ready; a result transfers on
  // the clock edge where both are high, and cdb_grant without cdb_req has no effect.
  // The buffer head has priority; an empty buffer bypasses the live pipeline result.
  assign cdb_req   = reset & ~squash & (~buf_empty | live);
  assign presented = cdb_req ? (buf_empty ? incoming : buf_mem[head]) : '0;
  assign {cdb_value, cdb_prf_idx, cdb_rob_idx, cdb_PC} = presented;

  assign fire = cdb_req & cdb_grant;
  assign pop  = fire & ~buf_empty;
  assign push = live & ~(fire & buf_empty);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr      <= '0;
      stage_valid <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      if (mul_enable) rr_ptr <= gnt_idx + IDX_W'(1);
      if (squash) begin
        stage_valid <= '0;
        head        <= '0;
        tail        <= '0;
        count       <= '0;
      end else begin
        stage_valid <= {stage_valid[STAGE-2:0], mul_enable};
        if (push) tail <= next_ptr(tail);
        if (pop)  head <= next_ptr(head);
        count <= count + CRED_W'(push) - CRED_W'(pop);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push && !squash) buf_mem[tail] <= incoming;
  end

  a_count_bound: assert property (@(posedge clock) disable iff (!reset)
    count <= DEPTH_C);
  a_gnt_onehot: assert property (@(posedge clock) disable iff (!reset)
    $onehot0(gnt));
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(live && count == DEPTH_C && !cdb_grant));

endmodule

// File: tb/tb_mul_issue_sched.sv
// Bench for mul_issue_sched: arbitration vector table, multi-cycle corner sequences,
// and a scoreboard that checks every CDB result against an 8-stage multiplier model.
module tb_mul_issue_sched;
  localparam int NREQ      = 2;
  localparam int STAGE     = 8;
  localparam int BUF_DEPTH = 4;
  localparam int XLEN      = 32;
  localparam int PRF_LEN   = 6;
  localparam int ROB_LEN   = 5;
  localparam int CRED_W    = $clog2(BUF_DEPTH) + 1;
  localparam int PKT_W     = 2 * XLEN + PRF_LEN + ROB_LEN;

  logic                 clock;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic                 squash;
  logic [NREQ-1:0]      gnt;
  logic [0:0]           gnt_idx;
  logic                 mul_enable;
  logic                 mul_valid;
  logic [XLEN-1:0]      mul_value;
  logic [PRF_LEN-1:0]   mul_prf_idx;
  logic [ROB_LEN-1:0]   mul_rob_idx;
  logic [XLEN-1:0]      mul_PC;
  logic                 cdb_req;
  logic                 cdb_grant;
  logic [XLEN-1:0]      cdb_value;
  logic [PRF_LEN-1:0]   cdb_prf_idx;
  logic [ROB_LEN-1:0]   cdb_rob_idx;
  logic [XLEN-1:0]      cdb_PC;
  logic [CRED_W-1:0]    credits;

  mul_issue_sched #(
    .NREQ(NREQ), .STAGE(STAGE), .BUF_DEPTH(BUF_DEPTH),
    .XLEN(XLEN), .PRF_LEN(PRF_LEN), .ROB_LEN(ROB_LEN)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .squash(squash),
    .gnt(gnt), .gnt_idx(gnt_idx), .mul_enable(mul_enable),
    .mul_valid(mul_valid), .mul_value(mul_value), .mul_prf_idx(mul_prf_idx),
    .mul_rob_idx(mul_rob_idx), .mul_PC(mul_PC),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_value(cdb_value),
    .cdb_prf_idx(cdb_prf_idx), .cdb_rob_idx(cdb_rob_idx), .cdb_PC(cdb_PC),
    .credits(credits)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: actual %0h expected %0h at t=%0t", name, act, exp_v, $time);
  endtask

  // ---------------- multiplier model ----------------
  logic             pipe_v [STAGE];
  logic [PKT_W-1:0] pipe_d [STAGE];
  logic [PKT_W-1:0] issue_pkt;
  int unsigned      seq;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGE; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[0] <= mul_enable;
      pipe_d[0] <= issue_pkt;
      for (int i = 1; i < STAGE; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign mul_valid = pipe_v[STAGE-1];
  assign {mul_value, mul_prf_idx, mul_rob_idx, mul_PC} = pipe_d[STAGE-1];

  // ---------------- scoreboard ----------------
  logic [PKT_W-1:0] exp_q[$];
  logic [PKT_W-1:0] exp_pkt;

  always @(negedge clock) begin
    if (reset) begin
      if (cdb_req && cdb_grant) begin
        if (exp_q.size() == 0) begin
          check("cdb_spurious", 1, 0);
        end else begin
          exp_pkt = exp_q.pop_front();
          check("cdb_result", {cdb_value, cdb_prf_idx, cdb_rob_idx, cdb_PC}, exp_pkt);
        end
      end
      if (mul_enable) begin
        issue_pkt = {$urandom(), PRF_LEN'($urandom_range(0, 63)), ROB_LEN'(seq),
                     XLEN'(32'h0040_0000 + seq * 4)};
        exp_q.push_back(issue_pkt);
        seq++;
      end
      if (squash) exp_q.delete();
    end
  end

  // ---------------- driver helpers ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    squash    = 1'b0;
    repeat (n) cyc();
  endtask

  // ---------------- arbitration vector table ----------------
  typedef struct {
    int              pre_idle;
    logic [NREQ-1:0] req;
    logic            sq;
    logic [NREQ-1:0] gnt;
    logic [CRED_W-1:0] cred;
  } vec_t;

  vec_t vt [20];

  int first_req;
  int pulses;
  int req_seen;

  initial begin
    vt[0]  = '{12, 2'b00, 1'b0, 2'b00, 3'd4};
    vt[1]  = '{0,  2'b10, 1'b0, 2'b10, 3'd4};
    vt[2]  = '{0,  2'b11, 1'b0, 2'b01, 3'd3};
    vt[3]  = '{0,  2'b11, 1'b0, 2'b10, 3'd2};
    vt[4]  = '{0,  2'b11, 1'b0, 2'b01, 3'd1};
    vt[5]  = '{0,  2'b11, 1'b0, 2'b00, 3'd0};
    vt[6]  = '{0,  2'b01, 1'b0, 2'b00, 3'd0};
    vt[7]  = '{0,  2'b11, 1'b1, 2'b00, 3'd0};
    vt[8]  = '{0,  2'b01, 1'b0, 2'b01, 3'd4};
    vt[9]  = '{0,  2'b10, 1'b0, 2'b10, 3'd3};
    vt[10] = '{0,  2'b10, 1'b0, 2'b10, 3'd2};
    vt[11] = '{0,  2'b00, 1'b0, 2'b00, 3'd1};
    vt[12] = '{12, 2'b11, 1'b0, 2'b01, 3'd4};
    vt[13] = '{0,  2'b11, 1'b0, 2'b10, 3'd3};
    vt[14] = '{0,  2'b11, 1'b0, 2'b01, 3'd2};
    vt[15] = '{0,  2'b11, 1'b0, 2'b10, 3'd1};
    vt[16] = '{0,  2'b11, 1'b0, 2'b00, 3'd0};
    vt[17] = '{12, 2'b11, 1'b0, 2'b01, 3'd4};
    vt[18] = '{0,  2'b10, 1'b0, 2'b10, 3'd3};
    vt[19] = '{0,  2'b01, 1'b0, 2'b01, 3'd2};

    seq       = 0;
    issue_pkt = '0;
    reset     = 1'b0;
    req_valid = 2'b11;
    squash    = 1'b0;
    cdb_grant = 1'b1;

    // Reset state with requests pending
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_gnt", gnt, 0);
    check("rst_mul_enable", mul_enable, 0);
    check("rst_cdb_req", cdb_req, 0);
    check("rst_credits", credits, BUF_DEPTH);
    check("rst_cdb_value", cdb_value, 0);
    check("rst_cdb_rob", cdb_rob_idx, 0);
    @(posedge clock);
    #1;
    reset     = 1'b1;
    req_valid = '0;
    cyc();

    // Single issue, result bypassed to the CDB STAGE cycles later
    req_valid = 2'b01;
    @(negedge clock);
    check("b_gnt", gnt, 2'b01);
    check("b_gnt_idx", gnt_idx, 0);
    check("b_mul_enable", mul_enable, 1);
    cyc();
    req_valid = '0;
    first_req = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (cdb_req && first_req < 0) first_req = k;
      cyc();
    end
    check("b_bypass_latency", first_req, STAGE);

    // Vector table: round-robin, credit exhaustion, squash
    for (int r = 0; r < 20; r++) begin
      idle(vt[r].pre_idle);
      req_valid = vt[r].req;
      squash    = vt[r].sq;
      @(negedge clock);
      check($sformatf("vec%0d_gnt", r), gnt, vt[r].gnt);
      check($sformatf("vec%0d_credits", r), credits, vt[r].cred);
      if (vt[r].gnt != '0) check($sformatf("vec%0d_gnt_idx", r), gnt_idx, vt[r].gnt[1]);
      cyc();
    end
    idle(12);

    // Credit exhaustion with the CDB stalled, then drain in issue order
    cdb_grant = 1'b0;
    req_valid = 2'b01;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      check($sformatf("d%0d_gnt", k), gnt, (k < 4) ? 2'b01 : 2'b00);
      check($sformatf("d%0d_credits", k), credits, (k < 4) ? (4 - k) : 0);
      check($sformatf("d%0d_cdb_req", k), cdb_req, (k >= 8) ? 1 : 0);
      cyc();
    end
    cdb_grant = 1'b1;
    @(negedge clock);
    check("d12_gnt", gnt, 2'b00);
    check("d12_credits", credits, 0);
    check("d12_cdb_req", cdb_req, 1);
    cyc();
    @(negedge clock);
    check("d13_gnt", gnt, 2'b01);
    check("d13_credits", credits, 1);
    check("d13_cdb_req", cdb_req, 1);
    cyc();
    req_valid = '0;
    for (int k = 14; k < 16; k++) begin
      @(negedge clock);
      check($sformatf("d%0d_cdb_req", k), cdb_req, 1);
      cyc();
    end
    idle(16);

    // Two buffered entries, live arrival with grant: pop and push together
    cdb_grant = 1'b0;
    req_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("e%0d_gnt", k), gnt, 2'b01);
      cyc();
    end
    req_valid = '0;
    repeat (7) cyc();
    cdb_grant = 1'b1;
    @(negedge clock);
    check("e10_cdb_req", cdb_req, 1);
    check("e10_credits", credits, 1);
    cyc();
    @(negedge clock);
    check("e11_credits", credits, 2);
    check("e11_cdb_req", cdb_req, 1);
    cyc();
    @(negedge clock);
    check("e12_cdb_req", cdb_req, 1);
    cyc();
    @(negedge clock);
    check("e13_cdb_req", cdb_req, 0);
    check("e13_credits", credits, 4);
    idle(4);

    // Squash with three in flight and one buffered
    cdb_grant = 1'b0;
    req_valid = 2'b01;
    @(negedge clock);
    check("f0_gnt", gnt, 2'b01);
    cyc();
    idle(5);
    req_valid = 2'b01;
    for (int k = 6; k < 9; k++) begin
      @(negedge clock);
      check($sformatf("f%0d_gnt", k), gnt, 2'b01);
      cyc();
    end
    squash = 1'b1;
    @(negedge clock);
    check("f9_credits", credits, 0);
    check("f9_cdb_req", cdb_req, 0);
    check("f9_gnt", gnt, 2'b00);
    cyc();
    squash    = 1'b0;
    req_valid = '0;
    cdb_grant = 1'b1;
    @(negedge clock);
    check("f10_credits", credits, 4);
    pulses   = 0;
    req_seen = 0;
    for (int k = 10; k < 22; k++) begin
      @(negedge clock);
      if (mul_valid) pulses++;
      if (cdb_req) req_seen++;
      cyc();
    end
    check("f_stale_pulses", pulses, 3);
    check("f_stale_cdb_req", req_seen, 0);
    idle(4);

    // Asynchronous reset while an entry is buffered
    cdb_grant = 1'b0;
    req_valid = 2'b01;
    @(negedge clock);
    check("g0_gnt", gnt, 2'b01);
    cyc();
    req_valid = '0;
    repeat (8) cyc();
    req_valid = 2'b01;
    #1;
    check("g9_cdb_req_pre", cdb_req, 1);
    check("g9_gnt_pre", gnt, 2'b01);
    reset = 1'b0;
    #1;
    check("g9_cdb_req_rst", cdb_req, 0);
    check("g9_gnt_rst", gnt, 2'b00);
    check("g9_mul_enable_rst", mul_enable, 0);
    check("g9_credits_rst", credits, 4);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset     = 1'b1;
    req_valid = '0;
    cdb_grant = 1'b1;
    @(negedge clock);
    check("g_credits_after", credits, 4);
    check("g_cdb_req_after", cdb_req, 0);
    idle(12);

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
